// File: rtl/hexdisp.sv
// hexdisp: registered 8-digit seven-segment driver with PWM dimming, per-digit blink and
// tear-free loading at PWM frame boundaries. Define HEXDISP_LZB_EN for leading-zero blanking.
module hexdisp #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BLINK_HZ = 2,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [39:0]         in_data,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic [7:0]          blink_mask,
    output logic [55:0]         hex
);
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [39:0] ALL_BLANK = {8{5'b10000}};
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [39:0]         pending;
    logic [39:0]         shadow;
    logic                pend;
    logic [PWM_BITS-1:0] brightness_r;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic                frame_end;
    logic                xfer;
    logic                lit;
    logic [7:0]          lz_blank;
    logic [55:0]         hex_next;
`ifdef HEXDISP_LZB_EN
    logic                lz_run;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign frame_end = (pwm_cnt == PWM_MAX);
    assign xfer      = in_valid && in_ready;

    always_comb begin
        lit      = (pwm_cnt < brightness_r) || (brightness_r == PWM_MAX);
        lz_blank = '0;
        hex_next = '1;
`ifdef HEXDISP_LZB_EN
        // Blank zeros from the top down until the first digit that shows something.
        lz_run = 1'b1;
        for (int n = 7; n >= 1; n--) begin
            if (lz_run && shadow[5*n +: 5] == 5'd0)
                lz_blank[n] = 1'b1;
            else
                lz_run = 1'b0;
        end
`endif
        for (int n = 0; n < 8; n++) begin
            if (shadow[5*n+4] || !lit || (blink_mask[n] && blink_phase) || lz_blank[n])
                hex_next[7*n +: 7] = 7'h7F;
            else
                hex_next[7*n +: 7] = glyph(shadow[5*n +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= ALL_BLANK;
            shadow       <= ALL_BLANK;
            pend         <= 1'b0;
            in_ready     <= 1'b1;
            brightness_r <= '0;
            pwm_cnt      <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            hex          <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            // A transfer can only happen with pend clear, so it never collides with a commit.
            if (xfer) begin
                pending  <= in_data;
                pend     <= 1'b1;
                in_ready <= 1'b0;
            end else if (frame_end && pend) begin
                shadow   <= pending;
                pend     <= 1'b0;
                in_ready <= 1'b1;
            end
            if (frame_end)
                brightness_r <= brightness;
            hex <= hex_next;
        end
    end
endmodule

// File: tb/tb_hexdisp.sv
// tb_hexdisp: directed and randomized checks of hexdisp against a cycle-count based
// reference model (PWM_BITS=4, CLK_FREQ=64, BLINK_HZ=4 -> 16-cycle frames, 8-cycle blink).
`timescale 1ns/1ps
module tb_hexdisp;
    localparam int PB = 4;
    localparam logic [39:0] BLANK40 = {8{5'b10000}};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [39:0]   in_data = '0;
    logic [PB-1:0] brightness = '0;
    logic [7:0]    blink_mask = '0;
    logic [55:0]   hex;

    int compared = 0;
    int mismatched = 0;

    logic [39:0] m_pending = BLANK40;
    logic [39:0] m_shadow = BLANK40;
    bit          m_pend = 1'b0;
    int          m_bright = 0;
    int          cyc = 0;

    logic [6:0] gly [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    hexdisp #(.CLK_FREQ(64), .BLINK_HZ(4), .PWM_BITS(PB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .brightness(brightness), .blink_mask(blink_mask), .hex(hex)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] model_hex(input logic [39:0] sh, input int br, input int pwm,
                                              input bit phase, input logic [7:0] mask);
        logic [55:0] r;
        logic [4:0]  d;
        bit          on;
        bit          lz;
`ifdef HEXDISP_LZB_EN
        bit          lead;
        lead = 1'b1;
`endif
        r  = '1;
        on = (pwm < br) || (br == 15);
        for (int n = 7; n >= 0; n--) begin
            d  = sh[5*n +: 5];
            lz = 1'b0;
`ifdef HEXDISP_LZB_EN
            if (n > 0 && lead && d == 5'd0) lz = 1'b1;
            else lead = 1'b0;
`endif
            if (d[4] || !on || (mask[n] && phase) || lz) r[7*n +: 7] = 7'h7F;
            else r[7*n +: 7] = gly[d[3:0]];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the model's pre-edge state, advance the model, compare after the edge.
    task automatic step();
        logic [55:0] eh;
        bit          er;
        if (rst) begin
            eh = '1;
            m_pend = 1'b0; m_pending = BLANK40; m_shadow = BLANK40; m_bright = 0; cyc = 0;
        end else begin
            eh = model_hex(m_shadow, m_bright, cyc % 16, ((cyc / 8) % 2) == 1, blink_mask);
            if (in_valid && !m_pend) begin
                m_pending = in_data; m_pend = 1'b1;
            end else if (cyc % 16 == 15 && m_pend) begin
                m_shadow = m_pending; m_pend = 1'b0;
            end
            if (cyc % 16 == 15) m_bright = int'(brightness);
            cyc++;
        end
        er = !m_pend;
        @(posedge clk);
        #1;
        check("hex", 64'(hex), 64'(eh));
        check("in_ready", 64'(in_ready), 64'(er));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [39:0] d);
        int guard;
        in_data  = d;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 40) begin step(); guard++; end
        check("load_ready_timeout", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int          cnt;
        bit          found;
        logic [63:0] rnd;

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1; in_valid = 1'b1; in_data = 40'h0123456789;
        run(3);
        check("reset_hex", 64'(hex), 64'h00FFFFFFFFFFFFFF);
        check("reset_ready", 64'(in_ready), 64'(1));
        rst = 1'b0; in_valid = 1'b0;
        run(5);

        // Load 7..0 at full brightness; must appear within 17 cycles of the transfer.
        brightness = 4'd15;
        in_data = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ready_low_after_xfer", 64'(in_ready), 64'(0));
        found = 1'b0;
        for (int i = 0; i < 17 && !found; i++) begin
            step();
            if (hex[6:0] === 7'b1000000 && hex[13:7] === 7'b1111001) found = 1'b1;
        end
        check("load_latency", 64'(found), 64'(1));

        // Backpressure: a second write waits for in_ready, then shows at the next boundary.
        load({5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8});
        run(40);

        // Brightness 4: digit1 lit exactly 4 of 16 cycles.
        brightness = 4'd4;
        run(40);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (hex[13:7] !== 7'h7F) cnt++;
        end
        check("duty_4_of_16", 64'(cnt), 64'(4));

        brightness = 4'd0;
        run(40);
        check("dark_hex", 64'(hex), 64'h00FFFFFFFFFFFFFF);

        // Blink digit 0 at full brightness: blank 8 of every 16 cycles.
        brightness = 4'd15; blink_mask = 8'h01;
        run(40);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (hex[6:0] === 7'h7F) cnt++;
        end
        check("blink_8_of_16", 64'(cnt), 64'(8));
        blink_mask = 8'h00;

        // Leading-zero data 0x42 and all-zero data.
        load({5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd2});
        run(40);
        load('0);
        run(40);

        // Reset while a write is pending: it must be discarded.
        load({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8});
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom(), $urandom()};
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = rnd[39:0];
            if ($urandom_range(0, 15) == 0) brightness = PB'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) blink_mask = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
